// File: rtl/band_queue_pkg.sv
// band_queue_pkg: shared state type and default geometry for the band FIR sample queue.
package band_queue_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    READ = 1'b1
  } state_e;

  localparam int BQ_DEPTH    = 1536;
  localparam int BQ_READ_LEN = 1021;
  localparam int BQ_PTR_W    = $clog2(BQ_DEPTH);
  localparam int BQ_DATA_W   = 32;

endpackage

// File: rtl/band_queue_dpram.sv
// band_queue_dpram: simple dual-port stereo sample RAM, one write port, one registered read port.
// The read register returns zero whenever no read is requested, so idle cycles present silence.
module band_queue_dpram
  import band_queue_pkg::*;
#(
  parameter int DEPTH = BQ_DEPTH,
  parameter int AW    = BQ_PTR_W,
  parameter int DW    = BQ_DATA_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  // Storage array write port; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Registered read port, forced to zero outside active reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= {DW{1'b0}};
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end else begin
      rdata_q <= {DW{1'b0}};
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/band_queue.sv
// band_queue: circular stereo sample queue that replays the newest READ_LEN samples, oldest first.
// Define BAND_QUEUE_OVR_ERR_EN to add the sticky ovr_err output flagging a dropped readout.
module band_queue
  import band_queue_pkg::*;
#(
  parameter int DEPTH    = BQ_DEPTH,
  parameter int READ_LEN = BQ_READ_LEN
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               new_smpl,
  input  logic signed [15:0] lft_smpl,
  input  logic signed [15:0] rght_smpl,
  output logic               sequencing,
  output logic signed [15:0] lft_out,
  output logic signed [15:0] rght_out
`ifdef BAND_QUEUE_OVR_ERR_EN
  ,
  output logic               ovr_err
`endif
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = $clog2(READ_LEN + 1);

  state_e           state_q, state_d;
  logic             pending_q, pending_d;
  logic [AW-1:0]    new_ptr_q, new_ptr_d;
  logic [AW-1:0]    old_ptr_q, old_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] fill_cnt_q, fill_cnt_d;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic             reading_s, set_pend_s, lost_s, rd_last_s;
  logic [1:0]       old_step_s;
  logic [BQ_DATA_W-1:0] rd_data_s;

  function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p);
    if (p == AW'(DEPTH - 1)) begin
      return {AW{1'b0}};
    end else begin
      return p + AW'(1);
    end
  endfunction

  assign reading_s  = (state_q == READ);
  assign set_pend_s = new_smpl && (fill_cnt_q >= CNT_W'(READ_LEN - 1));
  // A request arriving while one is already queued drops a readout; old_ptr skips
  // ahead so the surviving readout still covers the newest window.
  assign lost_s     = set_pend_s && pending_q;
  assign rd_last_s  = reading_s && (rd_cnt_q == CNT_W'(READ_LEN - 1));
  assign old_step_s = {1'b0, rd_last_s} + {1'b0, lost_s};

  // Next-state logic for write pointer, fill level, window base and replay FSM.
  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    new_ptr_d  = new_ptr_q;
    old_ptr_d  = old_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    rd_cnt_d   = rd_cnt_q;
    fill_cnt_d = fill_cnt_q;

    if (new_smpl) begin
      new_ptr_d = wrap_inc(new_ptr_q);
      if (fill_cnt_q != CNT_W'(READ_LEN)) begin
        fill_cnt_d = fill_cnt_q + CNT_W'(1);
      end else begin
        fill_cnt_d = fill_cnt_q;
      end
    end else begin
      new_ptr_d = new_ptr_q;
    end

    case (old_step_s)
      2'd1:    old_ptr_d = wrap_inc(old_ptr_q);
      2'd2:    old_ptr_d = wrap_inc(wrap_inc(old_ptr_q));
      default: old_ptr_d = old_ptr_q;
    endcase

    case (state_q)
      IDLE: begin
        if (pending_q || set_pend_s) begin
          state_d   = READ;
          pending_d = 1'b0;
          rd_ptr_d  = lost_s ? wrap_inc(old_ptr_q) : old_ptr_q;
          rd_cnt_d  = {CNT_W{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        pending_d = pending_q || set_pend_s;
        rd_ptr_d  = wrap_inc(rd_ptr_q);
        if (rd_last_s) begin
          state_d  = IDLE;
          rd_cnt_d = {CNT_W{1'b0}};
        end else begin
          state_d  = READ;
          rd_cnt_d = rd_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        pending_d = 1'b0;
      end
    endcase
  end

  // State and pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pending_q  <= 1'b0;
      new_ptr_q  <= {AW{1'b0}};
      old_ptr_q  <= {AW{1'b0}};
      rd_ptr_q   <= {AW{1'b0}};
      rd_cnt_q   <= {CNT_W{1'b0}};
      fill_cnt_q <= {CNT_W{1'b0}};
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      new_ptr_q  <= new_ptr_d;
      old_ptr_q  <= old_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_cnt_q   <= rd_cnt_d;
      fill_cnt_q <= fill_cnt_d;
    end
  end

  band_queue_dpram #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (BQ_DATA_W)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (new_smpl),
    .waddr_i (new_ptr_q),
    .wdata_i ({lft_smpl, rght_smpl}),
    .re_i    (reading_s),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data_s)
  );

  assign sequencing = reading_s;
  assign lft_out    = rd_data_s[31:16];
  assign rght_out   = rd_data_s[15:0];

`ifdef BAND_QUEUE_OVR_ERR_EN
  logic ovr_err_q;

  // Sticky record of any dropped readout since reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovr_err_q <= 1'b0;
    end else if (lost_s) begin
      ovr_err_q <= 1'b1;
    end else begin
      ovr_err_q <= ovr_err_q;
    end
  end

  assign ovr_err = ovr_err_q;
`endif

endmodule

// File: tb/tb_band_queue.sv
// tb_band_queue: directed stimulus with a per-cycle schedule model of band_queue readouts.
module tb_band_queue;

  localparam int RL   = 1021;
  localparam int MAXC = 16384;

  logic               clk;
  logic               rst_n;
  logic               new_smpl;
  logic signed [15:0] lft_smpl;
  logic signed [15:0] rght_smpl;
  logic               sequencing;
  logic signed [15:0] lft_out;
  logic signed [15:0] rght_out;
`ifdef BAND_QUEUE_OVR_ERR_EN
  logic               ovr_err;
`endif

  band_queue dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .new_smpl   (new_smpl),
    .lft_smpl   (lft_smpl),
    .rght_smpl  (rght_smpl),
    .sequencing (sequencing),
    .lft_out    (lft_out),
    .rght_out   (rght_out)
`ifdef BAND_QUEUE_OVR_ERR_EN
    ,
    .ovr_err    (ovr_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  // Model: expected outputs per interval (index = number of rising edges so far).
  bit exp_seq [MAXC];
  int exp_l   [MAXC];
  int exp_r   [MAXC];
  int hl[$];
  int hr[$];
  bit waiting = 1'b0;
  int start_at = 0;
  int busy_last = -10;
  bit lost_seen = 1'b0;

  int cs [2400];
  int cl [2400];

  task automatic model_edge(input int e, input bit wr, input int l, input int r);
    int base;
    if (wr) begin
      hl.push_back(l);
      hr.push_back(r);
      if (hl.size() >= RL) begin
        if (waiting) lost_seen = 1'b1;
        else begin
          waiting  = 1'b1;
          start_at = (e >= busy_last + 2) ? e : busy_last + 2;
        end
      end
    end
    if (waiting && e == start_at) begin
      base = hl.size() - RL;
      for (int k = 0; k < RL; k++) begin
        if (e + k < MAXC) exp_seq[e + k] = 1'b1;
        if (e + 1 + k < MAXC) begin
          exp_l[e + 1 + k] = hl[base + k];
          exp_r[e + 1 + k] = hr[base + k];
        end
      end
      busy_last = e + RL - 1;
      waiting   = 1'b0;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      if (rst_n === 1'b1) model_edge(cyc, new_smpl, int'(lft_smpl), int'(rght_smpl));
    end
  end

  initial begin
    forever begin
      @(negedge rst_n);
      for (int i = cyc; i < MAXC; i++) begin
        exp_seq[i] = 1'b0;
        exp_l[i]   = 0;
        exp_r[i]   = 0;
      end
      hl.delete();
      hr.delete();
      waiting   = 1'b0;
      busy_last = -10;
      lost_seen = 1'b0;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    bit ok;
    forever begin
      @(negedge clk);
      if (cyc > 0 && cyc < MAXC) begin
        ok = (sequencing === exp_seq[cyc]) && (int'(lft_out) == exp_l[cyc]) &&
             (int'(rght_out) == exp_r[cyc]);
`ifdef BAND_QUEUE_OVR_ERR_EN
        ok = ok && (ovr_err === lost_seen);
`endif
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL cycle %0d: seq=%0b lft=%0d rght=%0d, expected seq=%0b lft=%0d rght=%0d",
                      cyc, sequencing, lft_out, rght_out, exp_seq[cyc], exp_l[cyc], exp_r[cyc]);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input int l, input int r);
    new_smpl  = 1'b1;
    lft_smpl  = 16'(l);
    rght_smpl = 16'(r);
    tick();
    new_smpl  = 1'b0;
  endtask

  task automatic capture(input int n);
    for (int c = 0; c < n; c++) begin
      cs[c] = int'(sequencing);
      cl[c] = int'(lft_out);
      tick();
    end
  endtask

  function automatic int count_high(input int n);
    int s = 0;
    for (int c = 0; c < n; c++) s += cs[c];
    return s;
  endfunction

  function automatic int last_rise(input int n);
    int r = -1;
    for (int c = 1; c < n; c++) if (cs[c] == 1 && cs[c - 1] == 0) r = c;
    return r;
  endfunction

  initial begin
    int fall;
    int rise;
    rst_n     = 1'b0;
    new_smpl  = 1'b0;
    lft_smpl  = 16'sd0;
    rght_smpl = 16'sd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_seq", int'(sequencing), 0);
    chk("reset_lft", int'(lft_out), 0);
    rst_n = 1'b1;
    tick();

    // Fill: 1020 samples never start a readout, the 1021st does.
    for (int i = 0; i < 1020; i++) write(i, -i);
    chk("fill_no_seq", int'(sequencing), 0);
    write(1020, -1020);
    capture(1100);
    chk("fill_seq_first", cs[0], 1);
    chk("fill_seq_len", count_high(1100), 1021);
    chk("fill_out_k1", cl[2], 1);
    chk("fill_out_last", cl[1021], 1020);
    chk("fill_out_after", cl[1022], 0);

    // Slide: oldest sample 0 leaves the window.
    write(1021, -1021);
    capture(1100);
    chk("slide_first", cl[1], 1);
    chk("slide_last", cl[1021], 1021);
    chk("slide_len", count_high(1100), 1021);

    // Overlap: a sample 500 cycles into a readout queues the next one.
    write(1022, -1022);
    repeat (500) tick();
    write(1023, -1023);
    capture(1700);
    fall = -1;
    rise = -1;
    for (int c = 1; c < 1700; c++) begin
      if (fall < 0 && cs[c] == 0) fall = c;
      if (fall >= 0 && rise < 0 && cs[c] == 1) rise = c;
    end
    chk("overlap_gap", rise - fall, 1);
    chk("overlap_first", (rise > 0) ? cl[rise + 1] : -1, 3);
    chk("overlap_last", (rise > 0) ? cl[rise + 1021] : -1, 1023);
`ifdef BAND_QUEUE_OVR_ERR_EN
    chk("ovr_clear", int'(ovr_err), 0);
`endif

    // Burst past the end of the RAM; the last readout holds the newest window.
    for (int i = 1024; i < 1600; i++) write(i, -i);
    capture(2300);
    rise = last_rise(2300);
    chk("wrap_first", (rise > 0) ? cl[rise + 1] : -1, 579);
    chk("wrap_addr0", (rise > 0) ? cl[rise + 958] : -1, 1536);
    chk("wrap_last", (rise > 0) ? cl[rise + 1021] : -1, 1599);
`ifdef BAND_QUEUE_OVR_ERR_EN
    chk("ovr_set", int'(ovr_err), 1);
`endif

    // Reset in the middle of a readout.
    write(1600, -1600);
    repeat (300) tick();
    chk("pre_reset_seq", int'(sequencing), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_seq", int'(sequencing), 0);
    chk("midreset_lft", int'(lft_out), 0);
    chk("midreset_rght", int'(rght_out), 0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Refill from scratch after reset.
    for (int i = 0; i < 1020; i++) write(3000 + i, -(3000 + i));
    chk("refill_no_seq", int'(sequencing), 0);
    write(4020, -4020);
    chk("refill_seq", int'(sequencing), 1);
    capture(1100);
    chk("refill_first", cl[1], 3000);
    chk("refill_last", cl[1021], 4020);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
